pad_strobe_rx: RTL and testbench
================================

// Module: pad_strobe_rx
// PURPOSE
//   Receive side of the bidirectional (optionally differential) strobe pad.
//   Samples pad_h/pad_l once the local driver has released the pad, waits out a bus-turnaround guard, locks on a low preamble, then emits per-edge pulses and an edge count.
//   Sits beside the pad output driver.
//   Reports a sticky fault when the differential pair stays non-complementary (contention, floating, X).
// PARAMETERS
//   DIFFERENTIAL  1  1: decode the pad_h/pad_l pair; 0: pad_h alone, pad_l ignored
//   TURN_CYC      2  guard cycles after driver release before preamble search (>=1)
//   PRE_LEN       2  consecutive valid-low samples that constitute a preamble (>=1)
//   GLITCH_MAX    1  consecutive invalid samples tolerated in ACTIVE before fault
//   CNT_W         8  width of edge_cnt
// PORTS
//   clk          in   1      single clock, all state on posedge
//   rst_n        in   1      asynchronous active-low reset
//   en           in   1      receive enable
//   drv_oe_n     in   1      local pad driver enable, active low (1 = pad released to far end)
//   pad_h        in   1      pad true leg (asynchronous)
//   pad_l        in   1      pad complement leg (asynchronous)
//   fault_clr    in   1      clears sticky fault
//   rx_active    out  1      1 while in ACTIVE
//   rx_level     out  1      last valid decoded level (holds through invalid samples)
//   strobe_rise  out  1      one-cycle pulse per decoded 0->1
//   strobe_fall  out  1      one-cycle pulse per decoded 1->0
//   edge_cnt     out  CNT_W  rising edges since ACTIVE entry, wraps modulo 2^CNT_W
//   fault        out  1      sticky pair/glitch fault
// BEHAVIOUR
//   Reset: all outputs 0, state IDLE, counters 0.
//   Sampling: each leg passes through a 2-flop synchroniser, followed by 1 registered decode stage.
//     Pad change to decode visible = 3 clk.
//     Pulses are registered from decode, so pad edge -> strobe_* pulse = 4 clk.
//   Decode (DIFFERENTIAL=1): h=1,l=0 -> valid 1; h=0,l=1 -> valid 0; h==l -> invalid.
//   Decode (DIFFERENTIAL=0): pad_h is always valid.
//     Any X on pad_h decodes as invalid, which is simulation only.
//   FSM states: IDLE, TURN, PRE, ACTIVE, ERROR.
//   IDLE:   when en&&drv_oe_n -> TURN, turn counter loaded with TURN_CYC-1.
//   TURN:   decrement each cycle; at 0 -> PRE.
//           Decode ignored, so driver release settling cannot cause a fault.
//   PRE:    pre counter increments on valid-0 and clears on valid-1 or invalid.
//           Reaching PRE_LEN -> ACTIVE.
//           edge_cnt cleared on PRE entry; no pulses emitted.
//   ACTIVE: compares decode with rx_level on every valid sample.
//           On a difference: rx_level updates and the matching pulse fires.
//           Rise increments edge_cnt, wrapping from 2^CNT_W-1 to 0.
//           The glitch counter counts consecutive invalid samples and clears on any valid sample.
//           Count > GLITCH_MAX -> ERROR, fault=1.
//   ERROR:  no pulses; rx_level and edge_cnt hold.
//   Global: en=0 or drv_oe_n=0 in any state -> IDLE on the next edge.
//     Pulses are suppressed in that same cycle.
//     rx_level and edge_cnt hold; fault keeps its value.
//   fault: set has priority over fault_clr in the same cycle.
//     fault_clr does not leave ERROR; only the global exit does.
//   Reset asserted mid-burst: immediate return to reset values, no pulse glitch.
// STRUCTURE
//   pad_rx_pkg: state enum (IDLE, TURN, PRE, ACTIVE, ERROR) and decode encoding {valid, level}.
//   Sub-module pad_sync2: 2-flop synchroniser with async active-low reset to 0.
//     One instance per leg; no other hierarchy.
// TESTING
//   1 Reset: rst_n=0 with pads toggling -> all outputs 0; release -> IDLE.
//     Nothing happens until drv_oe_n=1.
//   2 Burst, defaults: drv_oe_n 0->1, pads held low 6 clk, then 5 rise/fall pairs, 4 clk per half.
//     -> rx_active 6 clk after release, 5 strobe_rise, 5 strobe_fall, edge_cnt=5, fault=0.
//   3 Preamble broken: low, high, low low -> ACTIVE is entered only after the final two lows.
//     No pulses before that point.
//   4 Contention: in ACTIVE, force h=l=1 for 1 clk -> no fault.
//     Force h=l=1 for 2 clk -> ERROR, fault=1.
//     Pulse fault_clr while in ERROR -> fault=0, state stays ERROR.
//     drv_oe_n=0 -> IDLE.
//   5 Wrap: CNT_W=2, 5 rising edges -> edge_cnt 1,2,3,0,1.
//   6 Abort: drv_oe_n=0 the same cycle a rise pulse is due -> no pulse, IDLE next clk.
//     DIFFERENTIAL=0 rerun of case 2 with pad_l tied 1 -> identical results.

Source files
------------

// File: rtl/pad_rx_pkg.sv
// pad_rx_pkg: shared types and the pad-pair decode helper for the strobe receiver
//   state_e    receiver FSM states
//   dec_t      decoded pad sample {valid, level}
//   pad_decode maps one synchronised pad_h/pad_l sample to dec_t
package pad_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TURN,
        ST_PRE,
        ST_ACTIVE,
        ST_ERROR
    } state_e;

    typedef struct packed {
        logic valid;
        logic level;
    } dec_t;

    // Case equality makes an X/Z leg decode as invalid in simulation;
    // hardware legs are always 0/1, so this reduces to plain compares.
    function automatic dec_t pad_decode(logic h, logic l, bit diff);
        dec_t d;
        d.level = h;
        d.valid = diff ? ((h === 1'b1) && (l === 1'b0)) || ((h === 1'b0) && (l === 1'b1))
                       : (h === 1'b0) || (h === 1'b1);
        return d;
    endfunction

endpackage

// File: rtl/pad_strobe_rx_if.sv
// pad_strobe_rx_if: control, pad and result signals of the strobe receiver
//   en, drv_oe_n, pad_h, pad_l, fault_clr   driven by master, read by receiver
//   rx_active, rx_level, strobe_rise, strobe_fall, edge_cnt, fault   driven by receiver
interface pad_strobe_rx_if #(
    parameter int CNT_W = 8
);

    logic             en;
    logic             drv_oe_n;
    logic             pad_h;
    logic             pad_l;
    logic             fault_clr;
    logic             rx_active;
    logic             rx_level;
    logic             strobe_rise;
    logic             strobe_fall;
    logic [CNT_W-1:0] edge_cnt;
    logic             fault;

    modport master (
        output en, drv_oe_n, pad_h, pad_l, fault_clr,
        input  rx_active, rx_level, strobe_rise, strobe_fall, edge_cnt, fault
    );

    modport slave (
        input  en, drv_oe_n, pad_h, pad_l, fault_clr,
        output rx_active, rx_level, strobe_rise, strobe_fall, edge_cnt, fault
    );

endinterface

// File: rtl/pad_sync2.sv
// pad_sync2: two-flop synchroniser for one asynchronous pad leg
//   clk, rst_n   clock, asynchronous active-low reset (flops clear to 0)
//   d            asynchronous input
//   q            synchronised output, two clocks behind d
module pad_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/pad_strobe_rx.sv
// pad_strobe_rx: strobe pad receiver - sync, decode, turnaround guard, preamble lock, edge pulses/count
//   clk, rst_n   clock, asynchronous active-low reset
//   bus (slave)  in:  en, drv_oe_n (1 = pad released), pad_h, pad_l, fault_clr
//                out: rx_active, rx_level, strobe_rise, strobe_fall, edge_cnt, fault
module pad_strobe_rx
    import pad_rx_pkg::*;
#(
    parameter int DIFFERENTIAL = 1,
    parameter int TURN_CYC     = 2,
    parameter int PRE_LEN      = 2,
    parameter int GLITCH_MAX   = 1,
    parameter int CNT_W        = 8
) (
    input logic            clk,
    input logic            rst_n,
    pad_strobe_rx_if.slave bus
);

    localparam int TW = $clog2(TURN_CYC + 1);
    localparam int PW = $clog2(PRE_LEN + 1);
    localparam int GW = $clog2(GLITCH_MAX + 2);

    logic             h_s, l_s;
    state_e           state_q, state_d;
    dec_t             dec_q, dec_d;
    logic [TW-1:0]    turn_q, turn_d;
    logic [PW-1:0]    pre_q, pre_d;
    logic [GW-1:0]    glitch_q, glitch_d;
    logic             level_q, level_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             fault_q, fault_d;
    logic             fault_set;

    pad_sync2 u_sync_h (.clk(clk), .rst_n(rst_n), .d(bus.pad_h), .q(h_s));
    pad_sync2 u_sync_l (.clk(clk), .rst_n(rst_n), .d(bus.pad_l), .q(l_s));

    always_comb begin
        dec_d     = pad_decode(h_s, l_s, DIFFERENTIAL != 0);
        state_d   = state_q;
        turn_d    = turn_q;
        pre_d     = pre_q;
        glitch_d  = glitch_q;
        level_d   = level_q;
        cnt_d     = cnt_q;
        rise_d    = 1'b0;
        fall_d    = 1'b0;
        fault_set = 1'b0;
        // Losing enable or the pad going back to the local driver wins over
        // everything: straight to IDLE, no pulse, level/count/fault untouched.
        if (!(bus.en && bus.drv_oe_n)) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_TURN;
                    turn_d  = TW'(TURN_CYC - 1);
                end
                ST_TURN: begin
                    if (turn_q == '0) begin
                        state_d = ST_PRE;
                        pre_d   = '0;
                        cnt_d   = '0;
                    end else begin
                        turn_d = turn_q - TW'(1);
                    end
                end
                ST_PRE: begin
                    // The preamble was low, so the locked level starts at 0.
                    if (pre_q == PW'(PRE_LEN)) begin
                        state_d  = ST_ACTIVE;
                        level_d  = 1'b0;
                        glitch_d = '0;
                    end else begin
                        pre_d = (dec_q.valid && !dec_q.level) ? pre_q + PW'(1) : '0;
                    end
                end
                ST_ACTIVE: begin
                    if (!dec_q.valid) begin
                        glitch_d = glitch_q + GW'(1);
                        if (glitch_d > GW'(GLITCH_MAX)) begin
                            state_d   = ST_ERROR;
                            fault_set = 1'b1;
                        end
                    end else begin
                        glitch_d = '0;
                        if (dec_q.level != level_q) begin
                            level_d = dec_q.level;
                            rise_d  = dec_q.level;
                            fall_d  = !dec_q.level;
                            cnt_d   = dec_q.level ? cnt_q + CNT_W'(1) : cnt_q;
                        end
                    end
                end
                default: ;
            endcase
        end
        fault_d = fault_set || (fault_q && !bus.fault_clr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            dec_q    <= '0;
            turn_q   <= '0;
            pre_q    <= '0;
            glitch_q <= '0;
            level_q  <= 1'b0;
            cnt_q    <= '0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            dec_q    <= dec_d;
            turn_q   <= turn_d;
            pre_q    <= pre_d;
            glitch_q <= glitch_d;
            level_q  <= level_d;
            cnt_q    <= cnt_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            fault_q  <= fault_d;
        end
    end

    assign bus.rx_active   = (state_q == ST_ACTIVE);
    assign bus.rx_level    = level_q;
    assign bus.strobe_rise = rise_q;
    assign bus.strobe_fall = fall_q;
    assign bus.edge_cnt    = cnt_q;
    assign bus.fault       = fault_q;

endmodule

// File: tb/tb_pad_strobe_rx.sv
// tb_pad_strobe_rx: three receivers (differential, 2-bit counter, single-ended) against a behavioural model
module tb_pad_strobe_rx;

    localparam int TURN_CYC   = 2;
    localparam int PRE_LEN    = 2;
    localparam int GLITCH_MAX = 1;
    localparam int M_IDLE     = 0;
    localparam int M_GUARD    = 1;
    localparam int M_PRE      = 2;
    localparam int M_ACTIVE   = 3;
    localparam int M_ERROR    = 4;

    typedef struct {
        int mode;
        int guard_left;
        int lows;
        int bad_run;
        int edges;
        bit level;
        bit rise;
        bit fall;
        bit fault;
    } mdl_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b0;
    logic drv_oe_n = 1'b0;
    logic pad_h = 1'b0;
    logic pad_l = 1'b1;
    logic fault_clr = 1'b0;

    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;
    mdl_t m[3];
    bit   hh[4];
    bit   hl[4];
    int   n_rise[3];
    int   n_fall[3];
    bit   wrap_on = 1'b0;
    int   wi = 0;
    int   exp_wrap[5] = '{1, 2, 3, 0, 1};

    always #5 clk = ~clk;

    pad_strobe_rx_if #(.CNT_W(8)) bus_d ();
    pad_strobe_rx_if #(.CNT_W(2)) bus_w ();
    pad_strobe_rx_if #(.CNT_W(8)) bus_s ();

    assign bus_d.en = en;
    assign bus_d.drv_oe_n = drv_oe_n;
    assign bus_d.pad_h = pad_h;
    assign bus_d.pad_l = pad_l;
    assign bus_d.fault_clr = fault_clr;
    assign bus_w.en = en;
    assign bus_w.drv_oe_n = drv_oe_n;
    assign bus_w.pad_h = pad_h;
    assign bus_w.pad_l = pad_l;
    assign bus_w.fault_clr = fault_clr;
    assign bus_s.en = en;
    assign bus_s.drv_oe_n = drv_oe_n;
    assign bus_s.pad_h = pad_h;
    assign bus_s.pad_l = 1'b1;
    assign bus_s.fault_clr = fault_clr;

    pad_strobe_rx #(.DIFFERENTIAL(1), .CNT_W(8)) dut_d (.clk(clk), .rst_n(rst_n), .bus(bus_d.slave));
    pad_strobe_rx #(.DIFFERENTIAL(1), .CNT_W(2)) dut_w (.clk(clk), .rst_n(rst_n), .bus(bus_w.slave));
    pad_strobe_rx #(.DIFFERENTIAL(0), .CNT_W(8)) dut_s (.clk(clk), .rst_n(rst_n), .bus(bus_s.slave));

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One receiver clock as the spec describes it: guard countdown, preamble of
    // consecutive valid lows, then edge tracking with a tolerated invalid run.
    function automatic mdl_t mdl_step(mdl_t s, bit go, bit clr, bit v, bit lvl, int modulus);
        bit set_f = 1'b0;
        s.rise = 1'b0;
        s.fall = 1'b0;
        if (!go) begin
            s.mode = M_IDLE;
        end else if (s.mode == M_IDLE) begin
            s.mode = M_GUARD;
            s.guard_left = TURN_CYC - 1;
        end else if (s.mode == M_GUARD) begin
            if (s.guard_left == 0) begin
                s.mode = M_PRE;
                s.lows = 0;
                s.edges = 0;
            end else begin
                s.guard_left--;
            end
        end else if (s.mode == M_PRE) begin
            if (s.lows >= PRE_LEN) begin
                s.mode = M_ACTIVE;
                s.level = 1'b0;
                s.bad_run = 0;
            end else begin
                s.lows = (v && !lvl) ? s.lows + 1 : 0;
            end
        end else if (s.mode == M_ACTIVE) begin
            if (!v) begin
                s.bad_run++;
                if (s.bad_run > GLITCH_MAX) begin
                    s.mode = M_ERROR;
                    set_f = 1'b1;
                end
            end else begin
                s.bad_run = 0;
                if (lvl != s.level) begin
                    s.level = lvl;
                    s.rise = lvl;
                    s.fall = !lvl;
                    if (lvl) s.edges = (s.edges + 1) % modulus;
                end
            end
        end
        s.fault = set_f || (s.fault && !clr);
        return s;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) m[i] = '{default: 0};
        for (int k = 0; k < 4; k++) begin
            hh[k] = 1'b0;
            hl[k] = 1'b0;
        end
    endtask

    task automatic cmp_dut(string t, int idx, logic act, logic lvl, logic r, logic f, logic [31:0] cnt, logic flt);
        check({t, ".rx_active"}, 32'(act), 32'(m[idx].mode == M_ACTIVE));
        check({t, ".rx_level"}, 32'(lvl), 32'(m[idx].level));
        check({t, ".strobe_rise"}, 32'(r), 32'(m[idx].rise));
        check({t, ".strobe_fall"}, 32'(f), 32'(m[idx].fall));
        check({t, ".edge_cnt"}, cnt, 32'(m[idx].edges));
        check({t, ".fault"}, 32'(flt), 32'(m[idx].fault));
    endtask

    task automatic compare_all();
        cmp_dut("dif", 0, bus_d.rx_active, bus_d.rx_level, bus_d.strobe_rise, bus_d.strobe_fall, 32'(bus_d.edge_cnt), bus_d.fault);
        cmp_dut("wrp", 1, bus_w.rx_active, bus_w.rx_level, bus_w.strobe_rise, bus_w.strobe_fall, 32'(bus_w.edge_cnt), bus_w.fault);
        cmp_dut("sgl", 2, bus_s.rx_active, bus_s.rx_level, bus_s.strobe_rise, bus_s.strobe_fall, 32'(bus_s.edge_cnt), bus_s.fault);
    endtask

    // The receiver acts at edge k on the pad value present before edge k-3.
    task automatic tick();
        @(posedge clk);
        for (int k = 3; k > 0; k--) begin
            hh[k] = hh[k-1];
            hl[k] = hl[k-1];
        end
        hh[0] = pad_h;
        hl[0] = pad_l;
        if (!rst_n) model_reset();
        else
            for (int i = 0; i < 3; i++)
                m[i] = mdl_step(m[i], en && drv_oe_n, fault_clr, (i == 2) || (hh[3] != hl[3]), hh[3], (i == 1) ? 4 : 256);
        cyc++;
        @(negedge clk);
        compare_all();
        if (bus_d.strobe_rise) n_rise[0]++;
        if (bus_d.strobe_fall) n_fall[0]++;
        if (bus_w.strobe_rise) n_rise[1]++;
        if (bus_w.strobe_fall) n_fall[1]++;
        if (bus_s.strobe_rise) n_rise[2]++;
        if (bus_s.strobe_fall) n_fall[2]++;
        if (wrap_on && bus_w.strobe_rise) begin
            if (wi < 5) check("wrap.edge_cnt", 32'(bus_w.edge_cnt), 32'(exp_wrap[wi]));
            wi++;
        end
    endtask

    task automatic ticks(int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic set_pad(bit lv);
        pad_h = lv;
        pad_l = !lv;
    endtask

    task automatic clr_counts();
        for (int i = 0; i < 3; i++) begin
            n_rise[i] = 0;
            n_fall[i] = 0;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        clr_counts();
        // Reset with pads toggling, then enable without releasing the pad.
        en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            pad_h = i[0];
            pad_l = !i[0];
            tick();
        end
        check("t1.rst_edge_cnt", 32'(bus_d.edge_cnt), 0);
        check("t1.rst_level", 32'(bus_d.rx_level), 0);
        check("t1.rst_fault", 32'(bus_d.fault), 0);
        rst_n = 1'b1;
        set_pad(1'b0);
        ticks(10);
        check("t1.no_release_active", 32'(bus_d.rx_active), 0);
        // Burst with defaults on all three receivers.
        clr_counts();
        wrap_on = 1'b1;
        drv_oe_n = 1'b1;
        ticks(5);
        check("t2.active_early", 32'(bus_d.rx_active), 0);
        tick();
        check("t2.active_at_6", 32'(bus_d.rx_active), 1);
        check("t2.sgl_active_at_6", 32'(bus_s.rx_active), 1);
        for (int p = 0; p < 5; p++) begin
            set_pad(1'b1);
            ticks(4);
            set_pad(1'b0);
            ticks(4);
        end
        ticks(6);
        wrap_on = 1'b0;
        check("t2.rises", 32'(n_rise[0]), 5);
        check("t2.falls", 32'(n_fall[0]), 5);
        check("t2.edge_cnt", 32'(bus_d.edge_cnt), 5);
        check("t2.fault", 32'(bus_d.fault), 0);
        check("t2.sgl_rises", 32'(n_rise[2]), 5);
        check("t2.sgl_falls", 32'(n_fall[2]), 5);
        check("t2.sgl_edge_cnt", 32'(bus_s.edge_cnt), 5);
        check("t5.wrap_count", 32'(wi), 5);
        // Broken preamble: low, high, low, low.
        drv_oe_n = 1'b0;
        set_pad(1'b1);
        ticks(3);
        clr_counts();
        drv_oe_n = 1'b1;
        set_pad(1'b0);
        tick();
        set_pad(1'b1);
        tick();
        set_pad(1'b0);
        ticks(5);
        check("t3.active_early", 32'(bus_d.rx_active), 0);
        tick();
        check("t3.active_at_8", 32'(bus_d.rx_active), 1);
        check("t3.no_pulses", 32'(n_rise[0] + n_fall[0]), 0);
        // Contention: one invalid sample tolerated, two are not.
        ticks(2);
        pad_h = 1'b1;
        pad_l = 1'b1;
        tick();
        set_pad(1'b0);
        ticks(5);
        check("t4.single_glitch_fault", 32'(bus_d.fault), 0);
        check("t4.single_glitch_active", 32'(bus_d.rx_active), 1);
        pad_h = 1'b1;
        pad_l = 1'b1;
        ticks(2);
        set_pad(1'b0);
        ticks(4);
        check("t4.double_glitch_fault", 32'(bus_d.fault), 1);
        check("t4.double_glitch_active", 32'(bus_d.rx_active), 0);
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        check("t4.fault_cleared", 32'(bus_d.fault), 0);
        clr_counts();
        set_pad(1'b1);
        ticks(4);
        set_pad(1'b0);
        ticks(4);
        check("t4.error_no_rise", 32'(n_rise[0]), 0);
        check("t4.error_fault_stays_clear", 32'(bus_d.fault), 0);
        check("t4.error_not_active", 32'(bus_d.rx_active), 0);
        drv_oe_n = 1'b0;
        ticks(2);
        // Abort on the very cycle a rise pulse is due.
        drv_oe_n = 1'b1;
        ticks(6);
        check("t6.active", 32'(bus_d.rx_active), 1);
        set_pad(1'b1);
        ticks(3);
        drv_oe_n = 1'b0;
        tick();
        check("t6.no_rise", 32'(bus_d.strobe_rise), 0);
        check("t6.sgl_no_rise", 32'(bus_s.strobe_rise), 0);
        check("t6.idle", 32'(bus_d.rx_active), 0);
        check("t6.level_holds", 32'(bus_d.rx_level), 0);
        check("t6.edge_cnt_holds", 32'(bus_d.edge_cnt), 0);
        tick();
        set_pad(1'b0);
        ticks(3);
        // Randomized bursts with glitches, aborts, fault clears and resets.
        for (int ep = 0; ep < 30; ep++) begin
            bit lv = 1'b0;
            if ($urandom_range(0, 7) == 0) do_reset();
            en = 1'b1;
            drv_oe_n = 1'b1;
            set_pad(1'b0);
            for (int c = 0; c < 60; c++) begin
                int r = $urandom_range(0, 99);
                if (r < 12) lv = !lv;
                if (r >= 90) begin
                    pad_h = 1'($urandom_range(0, 1));
                    pad_l = pad_h;
                end else begin
                    set_pad(lv);
                end
                fault_clr = ($urandom_range(0, 19) == 0);
                drv_oe_n = ($urandom_range(0, 39) != 0);
                en = ($urandom_range(0, 49) != 0);
                if ($urandom_range(0, 299) == 0) do_reset();
                else tick();
            end
            en = 1'b1;
            drv_oe_n = 1'b0;
            fault_clr = 1'b0;
            ticks(2);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
